// File: rtl/regbank_wb_arbiter.sv
// Register-bank writeback arbiter: ALU results take the write port first,
// load results queue in a small FIFO and drain on free cycles.
module regbank_wb_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             AluValid,
    input  logic [4:0]       AluAddr,
    input  logic [WIDTH-1:0] AluData,
    input  logic             MemValid,
    output logic             MemReady,
    input  logic [4:0]       MemAddr,
    input  logic [WIDTH-1:0] MemData,
    output logic [4:0]       AddrC,
    output logic [WIDTH-1:0] DataC,
    output logic             w,
    output logic [31:0]      Busy,
    output logic             PipeStall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [4:0] XZR = 5'd31;

    logic [DEPTH-1:0] live;
    logic [4:0]       ent_addr [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic alu_wr;
    logic push;
    logic pop;
    logic head_live;

    assign MemReady  = Rst_n && (count != CNT_FULL);
    assign PipeStall = Rst_n && (count == CNT_FULL);

    // XZR destinations never claim the port and never occupy a slot.
    assign alu_wr    = AluValid && (AluAddr != XZR);
    assign push      = MemValid && MemReady && (MemAddr != XZR);
    assign pop       = !alu_wr && (count != '0);
    assign head_live = live[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= MemAddr;
            ent_data[wr_ptr] <= MemData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
            w      <= 1'b0;
            AddrC  <= XZR;
            DataC  <= '0;
        end else begin
            // Younger ALU write kills older queued loads to the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr && live[i] && (ent_addr[i] == AluAddr)) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (alu_wr) begin
                w     <= 1'b1;
                AddrC <= AluAddr;
                DataC <= AluData;
            end else if (pop && head_live) begin
                w     <= 1'b1;
                AddrC <= ent_addr[rd_ptr];
                DataC <= ent_data[rd_ptr];
            end else begin
                w     <= 1'b0;
            end
        end
    end

    always_comb begin
        Busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                Busy[ent_addr[i]] = 1'b1;
            end
        end
        Busy[31] = 1'b0;
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: vector table for the ALU path, scoreboard
// of expected register writes for the load/drain sequences.
module tb_regbank_wb_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        AluValid;
    logic [4:0]  AluAddr;
    logic [63:0] AluData;
    logic        MemValid;
    logic        MemReady;
    logic [4:0]  MemAddr;
    logic [63:0] MemData;
    logic [4:0]  AddrC;
    logic [63:0] DataC;
    logic        w;
    logic [31:0] Busy;
    logic        PipeStall;

    regbank_wb_arbiter #(.WIDTH(64), .DEPTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady),
        .MemAddr(MemAddr), .MemData(MemData),
        .AddrC(AddrC), .DataC(DataC), .w(w),
        .Busy(Busy), .PipeStall(PipeStall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        exp_w;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vec [6];
    int   total;
    int   passed;
    logic mon_en;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (mon_en && w === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got X%0d=%0h, expected none",
                         AddrC, DataC);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(AddrC), 64'(e.addr));
                chk("wr_data", DataC, e.data);
            end
        end
    end

    initial begin
        int ld;
        int acc_cyc;
        logic acc;
        total   = 0;
        passed  = 0;
        mon_en  = 1'b0;
        Rst_n   = 1'b0;
        AluValid = 1'b0;
        AluAddr = 5'd0;
        AluData = '0;
        MemValid = 1'b1;
        MemAddr = 5'd5;
        MemData = 64'h55;

        vec[0] = '{1'b1, 5'd7,  64'h11, 1'b1, 5'd7,  64'h11};
        vec[1] = '{1'b1, 5'd31, 64'h22, 1'b0, 5'd7,  64'h11};
        vec[2] = '{1'b0, 5'd3,  64'h33, 1'b0, 5'd7,  64'h11};
        vec[3] = '{1'b1, 5'd0,  64'h44, 1'b1, 5'd0,  64'h44};
        vec[4] = '{1'b1, 5'd30, '1,     1'b1, 5'd30, '1};
        vec[5] = '{1'b0, 5'd30, 64'h66, 1'b0, 5'd30, '1};

        // T1 reset with a load offered
        tick();
        tick();
        chk("rst_memready", 64'(MemReady), 0);
        chk("rst_w", 64'(w), 0);
        chk("rst_addrc", 64'(AddrC), 31);
        chk("rst_datac", DataC, 0);
        chk("rst_busy", 64'(Busy), 0);
        chk("rst_stall", 64'(PipeStall), 0);
        idle_in();
        Rst_n = 1'b1;
        tick();
        chk("idle_memready", 64'(MemReady), 1);

        // ALU path vectors
        for (int i = 0; i < 6; i++) begin
            AluValid = vec[i].av;
            AluAddr  = vec[i].aa;
            AluData  = vec[i].ad;
            tick();
            chk("vec_w", 64'(w), 64'(vec[i].exp_w));
            chk("vec_addrc", 64'(AddrC), 64'(vec[i].exp_addr));
            chk("vec_datac", DataC, vec[i].exp_data);
        end
        idle_in();
        tick();
        mon_en = 1'b1;

        // T2 ALU priority over queued load
        exp_wr(5'd7, 64'hB);
        exp_wr(5'd5, 64'hA);
        MemValid = 1'b1; MemAddr = 5'd5; MemData = 64'hA;
        tick();
        MemValid = 1'b0;
        AluValid = 1'b1; AluAddr = 5'd7; AluData = 64'hB;
        chk("t2_busy5_q", 64'(Busy[5]), 1);
        tick();
        AluValid = 1'b0;
        chk("t2_busy5_hold", 64'(Busy[5]), 1);
        tick();
        chk("t2_busy5_clr", 64'(Busy[5]), 0);
        tick();
        chk("t2_q_empty", 64'(exp_q.size()), 0);

        // T3 squash of older load
        exp_wr(5'd20, 64'h20);
        exp_wr(5'd21, 64'h21);
        exp_wr(5'd3, 64'h9);
        exp_wr(5'd4, 64'h2);
        MemValid = 1'b1; MemAddr = 5'd3; MemData = 64'h1;
        AluValid = 1'b1; AluAddr = 5'd20; AluData = 64'h20;
        tick();
        MemAddr = 5'd4; MemData = 64'h2;
        AluAddr = 5'd21; AluData = 64'h21;
        tick();
        MemValid = 1'b0;
        AluAddr = 5'd3; AluData = 64'h9;
        tick();
        chk("t3_busy3", 64'(Busy[3]), 0);
        chk("t3_busy4", 64'(Busy[4]), 1);
        AluValid = 1'b0;
        tick();
        chk("t3_dead_pop_w", 64'(w), 0);
        tick();
        tick();
        chk("t3_q_empty", 64'(exp_q.size()), 0);

        // T3b same-cycle load is younger than the ALU op
        exp_wr(5'd8, 64'hC);
        exp_wr(5'd8, 64'hD);
        AluValid = 1'b1; AluAddr = 5'd8; AluData = 64'hC;
        MemValid = 1'b1; MemAddr = 5'd8; MemData = 64'hD;
        tick();
        idle_in();
        chk("t3b_busy8", 64'(Busy[8]), 1);
        tick();
        tick();
        chk("t3b_q_empty", 64'(exp_q.size()), 0);

        // T4 full FIFO back-pressure
        for (int i = 1; i <= 6; i++) exp_wr(5'(i), 64'h100 + 64'(i));
        for (int k = 0; k < 5; k++) exp_wr(5'(10 + k), 64'h200 + 64'(k));
        ld = 0;
        acc_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            AluValid = (cyc <= 6);
            AluAddr  = 5'(cyc);
            AluData  = 64'h100 + 64'(cyc);
            MemValid = (ld < 5);
            MemAddr  = 5'(10 + ld);
            MemData  = 64'h200 + 64'(ld);
            acc = MemValid && MemReady;
            tick();
            if (acc) begin
                ld++;
                if (ld == 5) acc_cyc = cyc;
            end
            if (cyc == 4) begin
                chk("t4_ld_after4", 64'(ld), 4);
                chk("t4_memready_full", 64'(MemReady), 0);
                chk("t4_stall_full", 64'(PipeStall), 1);
            end
            if (cyc == 7) chk("t4_memready_popped", 64'(MemReady), 1);
        end
        idle_in();
        chk("t4_fifth_cycle", 64'(acc_cyc), 8);
        tick();
        chk("t4_q_empty", 64'(exp_q.size()), 0);
        chk("t4_stall_end", 64'(PipeStall), 0);

        // T5 XZR on both sources while draining
        exp_wr(5'd9, 64'h99);
        exp_wr(5'd2, 64'h22);
        MemValid = 1'b1; MemAddr = 5'd2; MemData = 64'h22;
        AluValid = 1'b1; AluAddr = 5'd9; AluData = 64'h99;
        tick();
        MemAddr = 5'd31; MemData = 64'hDEAD;
        AluAddr = 5'd31; AluData = 64'h77;
        tick();
        idle_in();
        chk("t5_busy", 64'(Busy), 0);
        chk("t5_memready", 64'(MemReady), 1);
        tick();
        tick();
        chk("t5_q_empty", 64'(exp_q.size()), 0);

        // T6 pointer wrap over three fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                AluValid = 1'b1; AluAddr = 5'd30;
                AluData  = 64'h3000 + 64'(r * 16 + k);
                MemValid = 1'b1; MemAddr = 5'(16 + k);
                MemData  = 64'hC000 + 64'(r * 16 + k);
                exp_wr(5'd30, AluData);
                tick();
                if (k == 2) chk("t6_stall_3", 64'(PipeStall), 0);
            end
            chk("t6_stall_4", 64'(PipeStall), 1);
            chk("t6_memready_4", 64'(MemReady), 0);
            for (int k = 0; k < 4; k++)
                exp_wr(5'(16 + k), 64'hC000 + 64'(r * 16 + k));
            idle_in();
            for (int k = 0; k < 4; k++) tick();
            chk("t6_busy_drained", 64'(Busy), 0);
            chk("t6_stall_drained", 64'(PipeStall), 0);
            tick();
            chk("t6_w_idle", 64'(w), 0);
            chk("t6_q_empty", 64'(exp_q.size()), 0);
        end

        // T7 reset while entries are in flight
        exp_wr(5'd25, 64'h251);
        exp_wr(5'd25, 64'h252);
        exp_wr(5'd12, 64'h1);
        MemValid = 1'b1; MemAddr = 5'd12; MemData = 64'h1;
        AluValid = 1'b1; AluAddr = 5'd25; AluData = 64'h251;
        tick();
        MemAddr = 5'd13; MemData = 64'h2;
        AluData = 64'h252;
        tick();
        idle_in();
        tick();
        Rst_n = 1'b0;
        tick();
        chk("t7_rst_w", 64'(w), 0);
        chk("t7_rst_addrc", 64'(AddrC), 31);
        chk("t7_rst_busy", 64'(Busy), 0);
        chk("t7_rst_memready", 64'(MemReady), 0);
        Rst_n = 1'b1;
        tick();
        chk("t7_post_w", 64'(w), 0);
        tick();
        chk("t7_q_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
